program_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the program-memory RAM at consecutive word addresses. It holds the single-cycle core in reset while loading and releases it only after a checksum-verified load. It sits between the serial/debug byte source and the write port of the instruction memory, whose read side the core fetches from.

---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake and program-memory write port of the boot loader.
// The master modport is the loader side; the slave modport is the byte source and memory side.
interface program_loader_if;
    logic        Byte_Valid_i;
    logic [7:0]  Byte_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;

    modport master (
        input  Byte_Valid_i,
        input  Byte_i,
        output Byte_Ready_o,
        output Mem_Write_o,
        output Mem_Address_o,
        output Mem_Data_o
    );

    modport slave (
        output Byte_Valid_i,
        output Byte_i,
        input  Byte_Ready_o,
        input  Mem_Write_o,
        input  Mem_Address_o,
        input  Mem_Data_o
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: count byte, N little-endian words, XOR checksum byte.
// Holds the core in reset until a load finishes with a matching checksum.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start_i,
    program_loader_if.master  bus,
    output logic              Cpu_Hold_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              Error_o
);

    typedef enum logic [2:0] {
        StIdle, StCount, StData, StWrite, StCheck, StDone, StError
    } state_e;

    state_e                  r_state, w_state_d;
    logic [7:0]              r_count, w_count_d;
    logic [7:0]              r_word_idx, w_word_idx_d;
    logic [1:0]              r_byte_idx, w_byte_idx_d;
    logic [7:0]              r_csum, w_csum_d;
    logic [DATA_WIDTH-1:0]   r_word, w_word_d;
    logic [31:0]             r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0]   r_data, w_data_d;
    logic                    w_accept;
    logic                    w_count_bad;

    assign w_accept    = bus.Byte_Valid_i && bus.Byte_Ready_o;
    assign w_count_bad = (bus.Byte_i == 8'd0) || (32'(bus.Byte_i) > MEMORY_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_count    <= 8'd0;
            r_word_idx <= 8'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_word     <= '0;
            r_addr     <= BASE_ADDRESS;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_word_idx <= w_word_idx_d;
            r_byte_idx <= w_byte_idx_d;
            r_csum     <= w_csum_d;
            r_word     <= w_word_d;
            r_addr     <= w_addr_d;
            r_data     <= w_data_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_count_d    = r_count;
        w_word_idx_d = r_word_idx;
        w_byte_idx_d = r_byte_idx;
        w_csum_d     = r_csum;
        w_word_d     = r_word;
        w_addr_d     = r_addr;
        w_data_d     = r_data;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (Start_i) w_state_d = StCount;
            end
            StCount: begin
                if (w_accept) begin
                    if (w_count_bad) begin
                        w_state_d = StError;
                    end else begin
                        w_count_d    = bus.Byte_i;
                        w_word_idx_d = 8'd0;
                        w_byte_idx_d = 2'd0;
                        w_csum_d     = 8'd0;
                        w_state_d    = StData;
                    end
                end
            end
            StData: begin
                if (w_accept) begin
                    w_word_d[{r_byte_idx, 3'b000} +: 8] = bus.Byte_i;
                    w_csum_d     = r_csum ^ bus.Byte_i;
                    w_byte_idx_d = r_byte_idx + 2'd1;
                    // Address and data are captured here so they are stable for the whole WRITE cycle.
                    if (r_byte_idx == 2'd3) begin
                        w_addr_d  = BASE_ADDRESS + {22'd0, r_word_idx, 2'b00};
                        w_data_d  = w_word_d;
                        w_state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (r_word_idx == r_count - 8'd1) begin
                    w_state_d = StCheck;
                end else begin
                    w_word_idx_d = r_word_idx + 8'd1;
                    w_state_d    = StData;
                end
            end
            StCheck: begin
                if (w_accept) w_state_d = (bus.Byte_i == r_csum) ? StDone : StError;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign bus.Byte_Ready_o  = (r_state == StCount) || (r_state == StData) || (r_state == StCheck);
    assign bus.Mem_Write_o   = (r_state == StWrite);
    assign bus.Mem_Address_o = r_addr;
    assign bus.Mem_Data_o    = r_data;
    assign Busy_o            = bus.Byte_Ready_o || (r_state == StWrite);
    assign Done_o            = (r_state == StDone);
    assign Error_o           = (r_state == StError);
    assign Cpu_Hold_o        = (r_state != StDone);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as streams are built,
// a negedge monitor pops and compares every Mem_Write_o pulse.
module tb_program_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    program_loader_if bus ();

    program_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_i    (start),
        .bus        (bus.master),
        .Cpu_Hold_o (cpu_hold),
        .Busy_o     (busy),
        .Done_o     (done),
        .Error_o    (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_wr = 0;
    int          t0 = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    int          wr_cyc_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] prog[32];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts accepted bytes and scores every write strobe against the queue.
    always @(negedge clk) begin
        if (bus.Byte_Valid_i && bus.Byte_Ready_o) n_acc++;
        if (bus.Mem_Write_o) begin
            n_wr++;
            wr_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h@%h required none",
                         bus.Mem_Data_o, bus.Mem_Address_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.Mem_Address_o !== mon_e.addr || bus.Mem_Data_o !== mon_e.data) begin
                    errors++;
                    $display("FAIL mem_write got %h@%h required %h@%h", bus.Mem_Data_o,
                             bus.Mem_Address_o, mon_e.data, mon_e.addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    // Queue the stream for words 0..n-1 of prog and the matching expected writes.
    task automatic build(input int n, input bit bad_csum, output logic [7:0] cs);
        logic [7:0] b;
        tx_q = {};
        cs = 8'd0;
        tx_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = prog[i][8*j +: 8];
                tx_q.push_back(b);
                cs ^= b;
            end
            exp_q.push_back({BASE + 32'(4 * i), prog[i]});
        end
        tx_q.push_back(bad_csum ? 8'h00 : cs);
    endtask

    task automatic send_tx(input bit gaps);
        logic [7:0] b;
        int         k;
        int         waited;
        bit         ok;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            if (gaps) begin
                bus.Byte_Valid_i = 1'b0;
                k = int'($urandom_range(0, 2));
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                end
            end
            bus.Byte_Valid_i = 1'b1;
            bus.Byte_i       = b;
            ok     = 1'b0;
            waited = 0;
            while (!ok && waited < 100) begin
                @(negedge clk);
                if (bus.Byte_Ready_o) ok = 1'b1;
                else waited++;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout got none required accept of %h", b);
                tx_q = {};
            end
        end
        bus.Byte_Valid_i = 1'b0;
    endtask

    task automatic wait_end(output int lat);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (done || error) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL load_end_timeout got busy required done_or_error");
        end
        lat = cyc - t0;
    endtask

    logic [7:0] cs;
    int         lat;
    int         a0;
    int         w0;

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        bus.Byte_Valid_i = 1'b0;
        bus.Byte_i       = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(bus.Byte_Ready_o), 32'd0);
        chk("rst_addr", bus.Mem_Address_o, BASE);
        chk("rst_data", bus.Mem_Data_o, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        a0 = n_acc;
        bus.Byte_Valid_i = 1'b1;
        bus.Byte_i       = 8'h55;
        repeat (3) @(posedge clk);
        #1 bus.Byte_Valid_i = 1'b0;
        chk("idle_no_accept", 32'(n_acc - a0), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Two-word load; the XOR of the eight data bytes is 0x71
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        build(2, 1'b0, cs);
        chk("csum_hand", 32'(cs), 32'h71);
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.Byte_Ready_o), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        wr_cyc_q = {};
        send_tx(1'b0);
        wait_end(lat);
        chk("two_latency", 32'(lat), 32'd12);
        chk("two_done", {30'd0, done, error}, 32'd2);
        chk("two_hold", 32'(cpu_hold), 32'd0);
        chk("two_busy", 32'(busy), 32'd0);
        chk("two_nwrites", 32'(wr_cyc_q.size()), 32'd2);
        if (wr_cyc_q.size() == 2) begin
            chk("two_wr0_cycle", 32'(wr_cyc_q[0] - t0), 32'd5);
            chk("two_wr1_cycle", 32'(wr_cyc_q[1] - t0), 32'd10);
        end
        chk("two_queue_empty", 32'(exp_q.size()), 32'd0);

        // Bad checksum: writes still land, error flagged
        build(2, 1'b1, cs);
        pulse_start();
        chk("reload_done_clear", {30'd0, done, cpu_hold}, 32'd1);
        send_tx(1'b0);
        wait_end(lat);
        chk("badcs_flags", {29'd0, done, error, cpu_hold}, 32'd3);
        chk("badcs_queue_empty", 32'(exp_q.size()), 32'd0);

        // Bad counts 0x00 and 0x21
        w0 = n_wr;
        pulse_start();
        tx_q = {8'h00};
        send_tx(1'b0);
        chk("cnt0_error", {30'd0, error, busy}, 32'd2);
        pulse_start();
        tx_q = {8'h21};
        send_tx(1'b0);
        chk("cnt33_error", {30'd0, error, busy}, 32'd2);
        chk("badcnt_no_write", 32'(n_wr - w0), 32'd0);

        // Random gaps; bytes also held through WRITE
        build(2, 1'b0, cs);
        a0 = n_acc;
        w0 = n_wr;
        pulse_start();
        send_tx(1'b1);
        wait_end(lat);
        chk("gap_done", {30'd0, done, error}, 32'd2);
        chk("gap_accepts", 32'(n_acc - a0), 32'd10);
        chk("gap_writes", 32'(n_wr - w0), 32'd2);
        chk("gap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after 6 data bytes, then a full 32-word load
        for (int i = 0; i < 32; i++) prog[i] = 32'h0000_0013 + (32'(i) << 20) + 32'(i << 7);
        pulse_start();
        tx_q = {8'h20, prog[0][7:0], prog[0][15:8], prog[0][23:16], prog[0][31:24],
                prog[1][7:0], prog[1][15:8]};
        exp_q.push_back({BASE, prog[0]});
        send_tx(1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_flags", {27'd0, busy, done, error, cpu_hold, bus.Byte_Ready_o}, 32'd2);
        chk("mid_rst_write", 32'(bus.Mem_Write_o), 32'd0);
        chk("mid_rst_addr", bus.Mem_Address_o, BASE);
        chk("mid_rst_data", bus.Mem_Data_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_queue_empty", 32'(exp_q.size()), 32'd0);
        build(32, 1'b0, cs);
        w0 = n_wr;
        pulse_start();
        send_tx(1'b0);
        wait_end(lat);
        chk("full_latency", 32'(lat), 32'd162);
        chk("full_flags", {29'd0, done, error, cpu_hold}, 32'd4);
        chk("full_writes", 32'(n_wr - w0), 32'd32);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
